// File: rtl/bt656_stream_tx_if.sv
// bt656_stream_tx_if: AXI4-Stream pixel channel feeding the BT.656 transmitter.
// tdata[15:8] carries chroma (Cb on even pixels, Cr on odd), tdata[7:0] carries Y.
interface bt656_stream_tx_if;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/bt656_stream_tx.sv
// bt656_stream_tx: consumes YCbCr 4:2:2 pixels from an AXI4-Stream slave and
// emits a free-running progressive BT.656 byte stream with EAV/SAV codes.
// Build option BT656_TX_DVP_EN adds the DVP href/vsync sideband; without it
// both sideband outputs are tied low and the byte stream is unchanged.
module bt656_stream_tx #(
    parameter int H_ACTIVE   = 640,
    parameter int H_BLANK    = 272,
    parameter int V_ACTIVE   = 480,
    parameter int V_BLANK    = 45,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    bt656_stream_tx_if.slave s_axis,
    output logic [7:0]       bt656_data_o,
    output logic             bt656_href_o,
    output logic             bt656_vsync_o,
    output logic             underrun_o,
    output logic             sof_err_o,
    output logic             eol_err_o
);
    localparam int LB   = 8 + H_BLANK + 2 * H_ACTIVE;
    localparam int VT   = V_ACTIVE + V_BLANK;
    localparam int HW   = $clog2(LB);
    localparam int VW   = $clog2(VT + 1);
    localparam int PW   = HW - 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int SAV0 = 4 + H_BLANK;
    localparam int ACT0 = 8 + H_BLANK;

    // XY status word with F fixed at 0 and the Hamming protection bits
    function automatic logic [7:0] xy_code(input logic v, input logic h);
        logic f;
        f = 1'b0;
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    // Byte idx of an FF 00 00 XY timing reference
    function automatic logic [7:0] timing_ref(input logic [1:0] idx, input logic [7:0] xy);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'hFF;
            2'd3:    b = xy;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Keep 0x00/0xFF reserved for timing references
    function automatic logic [7:0] clamp(input logic [7:0] x);
        logic [7:0] r;
        if (x == 8'h00) begin
            r = 8'h01;
        end else if (x == 8'hFF) begin
            r = 8'hFE;
        end else begin
            r = x;
        end
        return r;
    endfunction

    logic [HW-1:0] hcnt_r;
    logic [VW-1:0] vcnt_r;
    logic          run_r;
    logic [17:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [7:0]    data_r;
    logic [7:0]    y_r;
    logic          idle_ph_r;
    logic          under_r;
    logic          sof_r;
    logic          eol_r;

    logic          live_s;
    logic          active_line_s;
    logic          h_wrap_s;
    logic          v_wrap_s;
    logic          in_act_s;
    logic [1:0]    sav_idx_s;
    logic [HW-1:0] act_off_s;
    logic [PW-1:0] pixel_s;
    logic [17:0]   head_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          push_s;
    logic          pop_s;
    logic [7:0]    byte_s;
    logic [7:0]    y_nxt_s;
    logic          under_s;
    logic          sof_s;
    logic          eol_s;
    logic          idle_ph_nxt_s;

    assign live_s        = run_r & enable_i;
    assign active_line_s = vcnt_r < VW'(V_ACTIVE);
    assign h_wrap_s      = hcnt_r == HW'(LB - 1);
    assign v_wrap_s      = vcnt_r == VW'(VT - 1);
    assign in_act_s      = hcnt_r >= HW'(ACT0);
    assign sav_idx_s     = hcnt_r[1:0] - 2'(SAV0);
    assign act_off_s     = hcnt_r - HW'(ACT0);
    assign pixel_s       = act_off_s[HW-1:1];
    assign head_s        = mem_r[rd_ptr_r];
    assign fifo_empty_s  = count_r == '0;
    assign fifo_full_s   = count_r == (AW + 1)'(FIFO_DEPTH);
    assign s_axis.tready = enable_i & ~rst & ~fifo_full_s;
    assign push_s        = s_axis.tvalid & s_axis.tready;

    // Byte selection, FIFO pop and per-pixel checks for the current position
    always_comb begin
        byte_s        = 8'h80;
        y_nxt_s       = y_r;
        pop_s         = 1'b0;
        under_s       = 1'b0;
        sof_s         = 1'b0;
        eol_s         = 1'b0;
        idle_ph_nxt_s = 1'b0;
        if (live_s) begin
            if (hcnt_r < HW'(4)) begin
                byte_s = timing_ref(hcnt_r[1:0], xy_code(~active_line_s, 1'b1));
            end else if (hcnt_r < HW'(SAV0)) begin
                byte_s = hcnt_r[0] ? 8'h10 : 8'h80;
            end else if (!in_act_s) begin
                byte_s = timing_ref(sav_idx_s, xy_code(~active_line_s, 1'b0));
            end else if (!active_line_s) begin
                byte_s = act_off_s[0] ? 8'h10 : 8'h80;
            end else if (act_off_s[0]) begin
                byte_s = y_r;
            end else if (fifo_empty_s) begin
                byte_s  = 8'h80;
                y_nxt_s = 8'h10;
                under_s = 1'b1;
            end else begin
                pop_s   = 1'b1;
                byte_s  = clamp(head_s[15:8]);
                y_nxt_s = clamp(head_s[7:0]);
                sof_s   = head_s[16] != ((vcnt_r == '0) && (pixel_s == '0));
                eol_s   = head_s[17] != (pixel_s == PW'(H_ACTIVE - 1));
            end
        end else begin
            byte_s        = idle_ph_r ? 8'h10 : 8'h80;
            idle_ph_nxt_s = ~idle_ph_r;
        end
    end

    // Line/byte timing counters; held at the origin while not running
    always_ff @(posedge clk) begin
        if (rst || !enable_i) begin
            run_r  <= 1'b0;
            hcnt_r <= '0;
            vcnt_r <= '0;
        end else begin
            run_r <= 1'b1;
            if (run_r && h_wrap_s) begin
                hcnt_r <= '0;
                vcnt_r <= v_wrap_s ? '0 : vcnt_r + VW'(1);
            end else if (run_r) begin
                hcnt_r <= hcnt_r + HW'(1);
            end
        end
    end

    // FIFO pointers and occupancy; flushed whenever the transmitter is stopped
    always_ff @(posedge clk) begin
        if (rst || !enable_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage: {tlast, tuser, tdata}
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {s_axis.tlast, s_axis.tuser, s_axis.tdata};
        end
    end

    // Registered byte stream, held luma and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r    <= 8'h80;
            y_r       <= 8'h10;
            idle_ph_r <= 1'b1;
            under_r   <= 1'b0;
            sof_r     <= 1'b0;
            eol_r     <= 1'b0;
        end else begin
            data_r    <= byte_s;
            y_r       <= y_nxt_s;
            idle_ph_r <= idle_ph_nxt_s;
            under_r   <= under_s;
            sof_r     <= sof_s;
            eol_r     <= eol_s;
        end
    end

    assign bt656_data_o = data_r;
    assign underrun_o   = under_r;
    assign sof_err_o    = sof_r;
    assign eol_err_o    = eol_r;

`ifdef BT656_TX_DVP_EN
    logic href_r;
    logic vsync_r;

    // DVP qualifiers registered in step with the data byte
    always_ff @(posedge clk) begin
        if (rst) begin
            href_r  <= 1'b0;
            vsync_r <= 1'b0;
        end else begin
            href_r  <= live_s & active_line_s & in_act_s;
            vsync_r <= live_s & ~active_line_s;
        end
    end

    assign bt656_href_o  = href_r;
    assign bt656_vsync_o = vsync_r;
`else
    assign bt656_href_o  = 1'b0;
    assign bt656_vsync_o = 1'b0;
`endif

endmodule

// File: tb/tb_bt656_stream_tx.sv
// Testbench for bt656_stream_tx: vector table for the underrun line, directed
// sessions for the frame-source corner cases and a randomized session, all
// compared against a frame-template reference model.
`timescale 1ns/1ps
module tb_bt656_stream_tx;
    localparam int HA   = 4;
    localparam int HB   = 4;
    localparam int VA   = 2;
    localparam int VB   = 1;
    localparam int FD   = 8;
    localparam int LB   = 8 + HB + 2 * HA;
    localparam int FR   = LB * (VA + VB);
    localparam int ACT0 = 8 + HB;
    localparam int PF   = VA * HA;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable_i = 1'b0;
    logic [7:0] bt656_data_o;
    logic       bt656_href_o;
    logic       bt656_vsync_o;
    logic       underrun_o;
    logic       sof_err_o;
    logic       eol_err_o;

    bt656_stream_tx_if s_axis ();

    always #5 clk = ~clk;

    bt656_stream_tx #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .s_axis(s_axis),
        .bt656_data_o(bt656_data_o), .bt656_href_o(bt656_href_o),
        .bt656_vsync_o(bt656_vsync_o), .underrun_o(underrun_o),
        .sof_err_o(sof_err_o), .eol_err_o(eol_err_o)
    );

    typedef struct {
        bit         en;
        bit         chk;
        logic [7:0] data;
        bit         under;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          tmpl [FR];
    logic [17:0] m_q [$];
    bit          m_run = 1'b0;
    int          m_pos = 0;
    bit          m_ph  = 1'b1;
    logic [7:0]  m_y   = 8'h10;
    int          m_last_pos = -1;
    int          n_sof, n_eol, n_under;
    logic [7:0]  cap [FR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] clamp(input logic [7:0] x);
        if (x == 8'h00) return 8'h01;
        if (x == 8'hFF) return 8'hFE;
        return x;
    endfunction

    // Whole-frame byte template; -1 marks an active pixel slot fed from the FIFO
    function automatic void build_tmpl();
        for (int l = 0; l < VA + VB; l++) begin
            bit v;
            v = (l >= VA);
            for (int b = 0; b < LB; b++) begin
                int val;
                if (b < 4)
                    val = (b == 0) ? 'hFF : (b == 3) ? (v ? 'hB6 : 'h9D) : 0;
                else if (b < 4 + HB)
                    val = ((b - 4) % 2 == 0) ? 'h80 : 'h10;
                else if (b < ACT0)
                    val = (b == 4 + HB) ? 'hFF : (b == ACT0 - 1) ? (v ? 'hAB : 'h80) : 0;
                else
                    val = v ? (((b - ACT0) % 2 == 0) ? 'h80 : 'h10) : -1;
                tmpl[l * LB + b] = val;
            end
        end
    endfunction

    // One clock: predict from the model, advance, compare after the edge
    task automatic cycle(output bit acc);
        logic [7:0]  ed;
        logic [17:0] e;
        bit eu, es, ee, eh, ev, rdy;
        int line, b, k;
        eu = 0; es = 0; ee = 0; eh = 0; ev = 0; acc = 0;
        rdy = enable_i && !rst && (m_q.size() < FD);
        m_last_pos = -1;
        if (rst) begin
            m_run = 0; m_pos = 0; m_q.delete(); m_ph = 1; ed = 8'h80;
        end else if (!enable_i) begin
            ed = m_ph ? 8'h10 : 8'h80; m_ph = !m_ph;
            m_run = 0; m_pos = 0; m_q.delete();
        end else begin
            if (!m_run) begin
                ed = m_ph ? 8'h10 : 8'h80; m_ph = !m_ph;
            end else begin
                m_ph = 0;
                line = m_pos / LB; b = m_pos % LB; m_last_pos = m_pos;
                ev = (line >= VA);
                if (tmpl[m_pos] >= 0) begin
                    ed = 8'(tmpl[m_pos]);
                end else begin
                    eh = 1; k = b - ACT0;
                    if (k % 2 == 1) begin
                        ed = m_y;
                    end else if (m_q.size() == 0) begin
                        ed = 8'h80; m_y = 8'h10; eu = 1;
                    end else begin
                        e = m_q.pop_front();
                        ed = clamp(e[15:8]); m_y = clamp(e[7:0]);
                        es = e[16] != (line == 0 && k == 0);
                        ee = e[17] != (k / 2 == HA - 1);
                    end
                end
                m_pos = (m_pos + 1) % FR;
            end
            m_run = 1;
            if (rdy && s_axis.tvalid) begin
                m_q.push_back({s_axis.tlast, s_axis.tuser, s_axis.tdata});
                acc = 1;
            end
        end
`ifndef BT656_TX_DVP_EN
        eh = 0; ev = 0;
`endif
        @(posedge clk);
        #1;
        check("data", bt656_data_o, ed);
        check("underrun", underrun_o, eu);
        check("sof_err", sof_err_o, es);
        check("eol_err", eol_err_o, ee);
        check("href", bt656_href_o, eh);
        check("vsync", bt656_vsync_o, ev);
        check("tready", s_axis.tready, enable_i && !rst && (m_q.size() < FD));
        n_sof += int'(sof_err_o); n_eol += int'(eol_err_o); n_under += int'(underrun_o);
    endtask

    function automatic logic [7:0] rnd_byte();
        case ($urandom_range(0, 9))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // Frame source: pixel i of an endless stream, with per-mode corruption
    task automatic set_src(input int mode, input int i, input int c, input int dis_at);
        logic [7:0] cb, y;
        bit tu, tl;
        cb = 8'(32'h20 + 2 * i); y = 8'(32'h30 + 2 * i);
        tu = (i % PF == 0); tl = (i % HA == HA - 1);
        s_axis.tvalid = 1'b1;
        case (mode)
            1: if (i == 0) begin cb = 8'h00; y = 8'hFF; end
            2: if (i == 0) tu = 0;
            3: if (i == 2) tl = 1;
            4: begin
                cb = rnd_byte(); y = rnd_byte();
                s_axis.tvalid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) tu = !tu;
                if ($urandom_range(0, 15) == 0) tl = !tl;
            end
            5: if (c >= dis_at) s_axis.tvalid = 1'b0;
            default: ;
        endcase
        s_axis.tdata = {cb, y}; s_axis.tuser = tu; s_axis.tlast = tl;
    endtask

    // Stop, restart and stream; optional 10-cycle enable gap at dis_at
    task automatic session(input int mode, input int ncyc, input int dis_at);
        int src;
        bit acc, cap_done;
        src = 0; cap_done = 0;
        enable_i = 0; s_axis.tvalid = 0;
        cycle(acc); cycle(acc);
        n_sof = 0; n_eol = 0; n_under = 0;
        for (int c = 0; c < ncyc; c++) begin
            enable_i = !(dis_at >= 0 && c >= dis_at && c < dis_at + 10);
            if (mode == 4 && $urandom_range(0, 149) == 0) enable_i = 0;
            if (dis_at >= 0 && c == dis_at + 10) n_under = 0;
            set_src(mode, src, c, dis_at);
            cycle(acc);
            if (acc) src++;
            if (m_last_pos >= 0 && !cap_done) begin
                cap[m_last_pos] = bt656_data_o;
                if (m_last_pos == FR - 1) cap_done = 1;
            end
            if (dis_at >= 0 && c == dis_at) check("tready_disabled", s_axis.tready, 1'b0);
            if (dis_at >= 0 && c == dis_at + 11) check("restart_ff", bt656_data_o, 8'hFF);
        end
    endtask

    initial begin
        vec_t       vec [21];
        logic [7:0] line0 [LB] = '{8'hFF, 8'h00, 8'h00, 8'h9D, 8'h80, 8'h10, 8'h80, 8'h10,
                                   8'hFF, 8'h00, 8'h00, 8'h80, 8'h80, 8'h10, 8'h80, 8'h10,
                                   8'h80, 8'h10, 8'h80, 8'h10};
        logic [7:0] blank [LB] = '{8'hFF, 8'h00, 8'h00, 8'hB6, 8'h80, 8'h10, 8'h80, 8'h10,
                                   8'hFF, 8'h00, 8'h00, 8'hAB, 8'h80, 8'h10, 8'h80, 8'h10,
                                   8'h80, 8'h10, 8'h80, 8'h10};
        bit acc;

        vec[0] = '{1'b1, 1'b0, 8'h00, 1'b0};
        for (int i = 0; i < LB; i++)
            vec[i + 1] = '{1'b1, 1'b1, line0[i], (i >= ACT0 && i % 2 == 0)};

        build_tmpl();
        s_axis.tvalid = 0; s_axis.tdata = '0; s_axis.tuser = 0; s_axis.tlast = 0;

        // Reset, including reset overriding a high enable
        rst = 1; enable_i = 0;
        cycle(acc); cycle(acc);
        enable_i = 1;
        cycle(acc);
        check("rst_data", bt656_data_o, 8'h80);
        check("rst_tready", s_axis.tready, 1'b0);
        rst = 0; enable_i = 0;
        cycle(acc); cycle(acc);

        // Line 0 with an empty FIFO
        for (int i = 0; i < 21; i++) begin
            enable_i = vec[i].en;
            cycle(acc);
            if (vec[i].chk) begin
                check("vec_data", bt656_data_o, vec[i].data);
                check("vec_underrun", underrun_o, vec[i].under);
            end
        end

        // Continuous frame source over three frames
        session(0, 1 + 3 * FR, -1);
        check("first_cb", cap[ACT0], 8'h20);
        check("first_y", cap[ACT0 + 1], 8'h30);
        for (int j = 0; j < LB; j++) check("blank_line", cap[VA * LB + j], blank[j]);
        check("clean_sof", n_sof, 0);
        check("clean_eol", n_eol, 0);
        check("clean_under", n_under, 0);

        // Clamp of reserved codes
        session(1, 1 + FR, -1);
        check("clamp_cb", cap[ACT0], 8'h01);
        check("clamp_y", cap[ACT0 + 1], 8'hFE);

        // Missing tuser at frame start
        session(2, 1 + 2 * FR, -1);
        check("sof_count", n_sof, 1);
        check("sof_no_eol", n_eol, 0);

        // Early tlast on pixel 2
        session(3, 1 + 2 * FR, -1);
        check("eol_count", n_eol, 1);
        check("eol_no_sof", n_sof, 0);

        // Enable dropped mid-active-line for 10 cycles; FIFO must come back empty
        session(5, 15 + 31, 15);
        check("flush_underruns", n_under, HA);

        // Randomized stream against the model
        session(4, 900, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
